// File: rtl/dmem_arb_pkg.sv
// Shared types and width constants for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the loader/debug port and the data memory.
interface dmem_arbiter_if;
  import dmem_arb_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_rvalid;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_data_out;

  // Requests are held until completion (cpu: cpu_stall low, ldr: ldr_gnt high);
  // read data arrives as a one-cycle rvalid pulse with rdata valid alongside it.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rdata, ldr_rvalid,
    output mem_address, mem_write_data, mem_read, mem_write,
    input  mem_data_out
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rdata, ldr_rvalid,
    input  mem_address, mem_write_data, mem_read, mem_write,
    output mem_data_out
  );
endinterface

// File: rtl/dmem_arb_fairness.sv
// Grant decision with a CPU burst limit so the loader cannot be starved.
module dmem_arb_fairness
  import dmem_arb_pkg::*;
#(
  parameter int MAX_CPU_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic idle,
  output logic grant_cpu,
  output logic grant_ldr
);
  localparam int BCW = $clog2(MAX_CPU_BURST + 1);
  localparam logic [BCW-1:0] BMAX = BCW'(MAX_CPU_BURST);

  logic [BCW-1:0] burst_cnt;

  assign grant_ldr = idle & ldr_req & (~cpu_req | (burst_cnt == BMAX));
  assign grant_cpu = idle & cpu_req & ~grant_ldr;

  // Counts CPU grants only while the loader is waiting; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= '0;
    end else if (!ldr_req || grant_ldr) begin
      burst_cnt <= '0;
    end else if (grant_cpu && burst_cnt != BMAX) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU MEM stage vs loader/debug port,
// with read-latency sequencing and pipeline stall generation.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LAT       = 1,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus,
  output state_t         dbg_state
);
  localparam int WCW = $clog2(MEM_LAT + 1);
  localparam logic [WCW-1:0] WLAT = WCW'(MEM_LAT);
  localparam logic [WCW-1:0] WONE = WCW'(1);

  state_t            state;
  owner_t            owner;
  logic [WCW-1:0]    wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ldr_rdata_q;
  logic              cpu_rvalid_q;
  logic              ldr_rvalid_q;

  logic              idle;
  logic              grant_cpu;
  logic              grant_ldr;
  logic              issue;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign idle = (state == IDLE) && !reset;

  dmem_arb_fairness #(.MAX_CPU_BURST(MAX_CPU_BURST)) u_fairness (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (bus.cpu_req),
    .ldr_req   (bus.ldr_req),
    .idle      (idle),
    .grant_cpu (grant_cpu),
    .grant_ldr (grant_ldr)
  );

  assign issue     = grant_cpu | grant_ldr;
  assign win_we    = grant_ldr ? bus.ldr_we    : bus.cpu_we;
  assign win_addr  = grant_ldr ? bus.ldr_addr  : bus.cpu_addr;
  assign win_wdata = grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;

  // Issue is combinational from the winner; otherwise the last issued values hold.
  assign bus.mem_address    = issue ? win_addr  : addr_q;
  assign bus.mem_write_data = issue ? win_wdata : wdata_q;
  assign bus.mem_write      = issue & win_we;
  assign bus.mem_read       = (issue & ~win_we) | (state == WAIT);
  assign bus.ldr_gnt        = grant_ldr;
  assign bus.cpu_stall      = bus.cpu_req & ~((grant_cpu & bus.cpu_we) | cpu_rvalid_q);

  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ldr_rdata  = ldr_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ldr_rvalid = ldr_rvalid_q;
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= OWN_CPU;
      wait_cnt     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
            if (!win_we) begin
              owner    <= grant_ldr ? OWN_LDR : OWN_CPU;
              wait_cnt <= WLAT;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == WONE) begin
            wait_cnt <= '0;
            state    <= RESP;
            if (owner == OWN_LDR) begin
              ldr_rdata_q  <= bus.mem_data_out;
              ldr_rvalid_q <= 1'b1;
            end else begin
              cpu_rdata_q  <= bus.mem_data_out;
              cpu_rvalid_q <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: MEM_LAT=1 instance plus a MEM_LAT=3 instance.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] cpu_exp_q[$];
  logic [31:0] ldr_exp_q[$];
  logic [31:0] cpu3_exp_q[$];

  dmem_arbiter_if b1 ();
  dmem_arbiter_if b3 ();
  state_t st1;
  state_t st3;

  dmem_arbiter #(.MEM_LAT(1), .MAX_CPU_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (b1.slave),
    .dbg_state (st1)
  );

  dmem_arbiter #(.MEM_LAT(3), .MAX_CPU_BURST(4)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .bus       (b3.slave),
    .dbg_state (st3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- memory models ----------------
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] pipe3 [0:2];
  logic [31:0] rd1;

  always @(posedge clk) begin
    if (b1.mem_write) mem1[b1.mem_address[7:0]] <= b1.mem_write_data;
    rd1 <= b1.mem_read ? mem1[b1.mem_address[7:0]] : 32'hBAD0_BAD0;
  end
  assign b1.mem_data_out = rd1;

  always @(posedge clk) begin
    pipe3[0] <= b3.mem_read ? mem3[b3.mem_address[7:0]] : 32'hBAD0_BAD3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b3.mem_data_out = pipe3[2];

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (b1.cpu_rvalid === 1'b1) begin
      if (cpu_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cpu_rvalid_unexpected actual=1 expected=0 rdata=%h", b1.cpu_rdata);
      end else begin
        chk("cpu_rdata", b1.cpu_rdata, cpu_exp_q.pop_front());
      end
    end
    if (b1.ldr_rvalid === 1'b1) begin
      if (ldr_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ldr_rvalid_unexpected actual=1 expected=0 rdata=%h", b1.ldr_rdata);
      end else begin
        chk("ldr_rdata", b1.ldr_rdata, ldr_exp_q.pop_front());
      end
    end
    if (b3.cpu_rvalid === 1'b1) begin
      if (cpu3_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cpu3_rvalid_unexpected actual=1 expected=0 rdata=%h", b3.cpu_rdata);
      end else begin
        chk("cpu3_rdata", b3.cpu_rdata, cpu3_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    b1.cpu_req   = req;
    b1.cpu_we    = we;
    b1.cpu_addr  = addr;
    b1.cpu_wdata = wdata;
  endtask

  task automatic ldr_set(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    b1.ldr_req   = req;
    b1.ldr_we    = we;
    b1.ldr_addr  = addr;
    b1.ldr_wdata = wdata;
  endtask

  // Bounded wait for the held CPU request to complete (cpu_stall drops).
  task automatic wait_cpu_done(input int bound);
    logic done;
    done = 1'b0;
    for (int n = 0; n < bound && !done; n++) begin
      step();
      @(negedge clk);
      if (b1.cpu_stall === 1'b0) done = 1'b1;
    end
    chk("cpu_done_in_budget", {31'd0, done}, 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    ldr_set(1'b0, 1'b0, 32'h0, 32'h0);
    b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = 32'h0; b3.cpu_wdata = 32'h0;
    b3.ldr_req = 1'b0; b3.ldr_we = 1'b0; b3.ldr_addr = 32'h0; b3.ldr_wdata = 32'h0;
    mem3[8'h30] = 32'hCAFE_F00D;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_state", 32'(st1), 32'(IDLE));
    chk("rst_cpu_stall", {31'd0, b1.cpu_stall}, 32'd0);
    chk("rst_cpu_rvalid", {31'd0, b1.cpu_rvalid}, 32'd0);
    chk("rst_ldr_rvalid", {31'd0, b1.ldr_rvalid}, 32'd0);
    chk("rst_ldr_gnt", {31'd0, b1.ldr_gnt}, 32'd0);
    chk("rst_mem_read", {31'd0, b1.mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, b1.mem_write}, 32'd0);
    chk("rst_mem_address", b1.mem_address, 32'h0);
    chk("rst_mem_write_data", b1.mem_write_data, 32'h0);
    chk("rst_cpu_rdata", b1.cpu_rdata, 32'h0);
    chk("rst_ldr_rdata", b1.ldr_rdata, 32'h0);

    // CPU write completes in its issue cycle
    step();
    cpu_set(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("wr_mem_write", {31'd0, b1.mem_write}, 32'd1);
    chk("wr_mem_read", {31'd0, b1.mem_read}, 32'd0);
    chk("wr_mem_address", b1.mem_address, 32'h10);
    chk("wr_mem_write_data", b1.mem_write_data, 32'hDEAD_BEEF);
    chk("wr_cpu_stall", {31'd0, b1.cpu_stall}, 32'd0);
    step();
    b1.cpu_req = 1'b0;

    // CPU read, MEM_LAT=1: issue, WAIT, RESP
    cpu_exp_q.push_back(32'hDEAD_BEEF);
    cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("rd_issue_mem_read", {31'd0, b1.mem_read}, 32'd1);
    chk("rd_issue_stall", {31'd0, b1.cpu_stall}, 32'd1);
    chk("rd_issue_addr", b1.mem_address, 32'h10);
    step();
    @(negedge clk);
    chk("rd_wait_state", 32'(st1), 32'(WAIT));
    chk("rd_wait_mem_read", {31'd0, b1.mem_read}, 32'd1);
    chk("rd_wait_stall", {31'd0, b1.cpu_stall}, 32'd1);
    chk("rd_wait_addr", b1.mem_address, 32'h10);
    step();
    @(negedge clk);
    chk("rd_resp_state", 32'(st1), 32'(RESP));
    chk("rd_resp_rvalid", {31'd0, b1.cpu_rvalid}, 32'd1);
    chk("rd_resp_stall", {31'd0, b1.cpu_stall}, 32'd0);
    chk("rd_resp_mem_read", {31'd0, b1.mem_read}, 32'd0);
    step();
    b1.cpu_req = 1'b0;

    // Both requesting writes: CPU x4 then LDR, repeating
    cpu_set(1'b1, 1'b1, 32'h40, 32'hA5A5_0040);
    ldr_set(1'b1, 1'b1, 32'h80, 32'h5A5A_0080);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("burst_ldr_gnt_%0d", i), {31'd0, b1.ldr_gnt}, (i % 5 == 4) ? 32'd1 : 32'd0);
      chk($sformatf("burst_addr_%0d", i), b1.mem_address, (i % 5 == 4) ? 32'h80 : 32'h40);
      chk($sformatf("burst_stall_%0d", i), {31'd0, b1.cpu_stall}, (i % 5 == 4) ? 32'd1 : 32'd0);
      step();
    end
    b1.cpu_req = 1'b0;
    b1.ldr_req = 1'b0;

    // LDR write 0x20, then LDR read of 0x20 with a CPU read arriving next cycle
    ldr_set(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    chk("ldr_wr_gnt", {31'd0, b1.ldr_gnt}, 32'd1);
    chk("ldr_wr_mem_write", {31'd0, b1.mem_write}, 32'd1);
    step();
    ldr_exp_q.push_back(32'h1234_5678);
    ldr_set(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("ldr_rd_gnt", {31'd0, b1.ldr_gnt}, 32'd1);
    chk("ldr_rd_mem_read", {31'd0, b1.mem_read}, 32'd1);
    step();
    b1.ldr_req = 1'b0;
    cpu_exp_q.push_back(32'hDEAD_BEEF);
    cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("ldr_wait_state", 32'(st1), 32'(WAIT));
    chk("ldr_wait_cpu_stall", {31'd0, b1.cpu_stall}, 32'd1);
    chk("ldr_wait_addr", b1.mem_address, 32'h20);
    chk("ldr_wait_gnt", {31'd0, b1.ldr_gnt}, 32'd0);
    step();
    @(negedge clk);
    chk("ldr_resp_cpu_stall", {31'd0, b1.cpu_stall}, 32'd1);
    chk("ldr_resp_rvalid", {31'd0, b1.ldr_rvalid}, 32'd1);
    step();
    @(negedge clk);
    chk("cpu_after_ldr_mem_read", {31'd0, b1.mem_read}, 32'd1);
    chk("cpu_after_ldr_addr", b1.mem_address, 32'h10);
    wait_cpu_done(8);
    step();
    b1.cpu_req = 1'b0;
    @(negedge clk);
    chk("ldr_rdata_hold", b1.ldr_rdata, 32'h1234_5678);

    // Reset during the WAIT cycle of a CPU read abandons it
    step();
    cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("rstw_issue_mem_read", {31'd0, b1.mem_read}, 32'd1);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_wait_state", 32'(st1), 32'(WAIT));
    step();
    reset = 1'b0;
    b1.cpu_req = 1'b0;
    @(negedge clk);
    chk("rstw_after_state", 32'(st1), 32'(IDLE));
    chk("rstw_after_mem_read", {31'd0, b1.mem_read}, 32'd0);
    chk("rstw_after_rvalid", {31'd0, b1.cpu_rvalid}, 32'd0);
    chk("rstw_after_rdata", b1.cpu_rdata, 32'h0);
    step();
    cpu_exp_q.push_back(32'hA5A5_0040);
    cpu_set(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    chk("rstw_new_mem_read", {31'd0, b1.mem_read}, 32'd1);
    wait_cpu_done(8);
    step();
    b1.cpu_req = 1'b0;

    // MEM_LAT=3 instance: three WAIT cycles, RESP in the 5th cycle
    cpu3_exp_q.push_back(32'hCAFE_F00D);
    b3.cpu_req  = 1'b1;
    b3.cpu_we   = 1'b0;
    b3.cpu_addr = 32'h30;
    @(negedge clk);
    chk("lat3_issue_state", 32'(st3), 32'(IDLE));
    chk("lat3_issue_mem_read", {31'd0, b3.mem_read}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("lat3_wait%0d_state", k), 32'(st3), 32'(WAIT));
      chk($sformatf("lat3_wait%0d_mem_read", k), {31'd0, b3.mem_read}, 32'd1);
      chk($sformatf("lat3_wait%0d_rvalid", k), {31'd0, b3.cpu_rvalid}, 32'd0);
      chk($sformatf("lat3_wait%0d_stall", k), {31'd0, b3.cpu_stall}, 32'd1);
    end
    step();
    @(negedge clk);
    chk("lat3_resp_state", 32'(st3), 32'(RESP));
    chk("lat3_resp_rvalid", {31'd0, b3.cpu_rvalid}, 32'd1);
    chk("lat3_resp_stall", {31'd0, b3.cpu_stall}, 32'd0);
    step();
    b3.cpu_req = 1'b0;
    @(negedge clk);
    chk("lat3_idle_state", 32'(st3), 32'(IDLE));
    chk("lat3_idle_mem_read", {31'd0, b3.mem_read}, 32'd0);

    // ---------------- final report ----------------
    step();
    chk("cpu_exp_q_drained", 32'(cpu_exp_q.size()), 32'd0);
    chk("ldr_exp_q_drained", 32'(ldr_exp_q.size()), 32'd0);
    chk("cpu3_exp_q_drained", 32'(cpu3_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the pipeline MEM stage (CPU port) and the program/data loader and debug port (LDR port).
- Arbitrates, sequences read latency, and returns read data.
- Stalls the pipeline while a CPU access is pending.
- Sits between the MEM stage and the data memory, and drives that memory's address, write_data, mem_read and mem_write inputs.

Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- MEM_LAT, 1, cycles from the read-issue cycle to mem_data_out being valid (>=1)
- MAX_CPU_BURST, 4, consecutive CPU grants allowed while LDR waits (>=1)

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until done
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  pipeline stall
- cpu_rdata  out  DATA_W  CPU read data
- cpu_rvalid  out  1  CPU read data valid, one-cycle pulse
- ldr_req  in  1  LDR request; held until ldr_gnt
- ldr_we  in  1  LDR write enable
- ldr_addr  in  ADDR_W  LDR address
- ldr_wdata  in  DATA_W  LDR write data
- ldr_gnt  out  1  LDR issue-cycle pulse
- ldr_rdata  out  DATA_W  LDR read data
- ldr_rvalid  out  1  LDR read data valid, one-cycle pulse
- mem_address  out  ADDR_W  to memory address
- mem_write_data  out  DATA_W  to memory write_data
- mem_read  out  1  to memory mem_read
- mem_write  out  1  to memory mem_write
- mem_data_out  in  DATA_W  from memory read data

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset state:
  - state = IDLE; burst_cnt = 0; wait_cnt = 0.
  - cpu_rdata = 0, ldr_rdata = 0.
  - cpu_rvalid, ldr_rvalid, ldr_gnt, mem_read, mem_write = 0.
  - mem_address = 0, mem_write_data = 0.
  - cpu_stall = cpu_req (combinational).
- States:
  - IDLE: accept a new request.
  - WAIT: read in flight; wait_cnt counts down from MEM_LAT.
  - RESP: one cycle; rvalid asserted, no issue.
- Arbitration, evaluated in IDLE only:
  - LDR wins if ldr_req & (~cpu_req | burst_cnt == MAX_CPU_BURST).
  - Otherwise the CPU wins if cpu_req.
- burst_cnt:
  - +1 on each CPU grant while ldr_req = 1, saturating at MAX_CPU_BURST.
  - Cleared on an LDR grant, or in any cycle with ldr_req = 0.
- Issue cycle, combinational from the winner's inputs:
  - mem_address = addr, mem_write_data = wdata.
  - mem_write = we, mem_read = ~we.
  - ldr_gnt = 1 if LDR won.
- Write:
  - Completes in the issue cycle; state stays IDLE.
  - CPU write: cpu_stall = 0 in that cycle.
  - Back-to-back writes sustain 1 per cycle.
- Read:
  - Winner's address and owner are latched; state -> WAIT, wait_cnt = MEM_LAT.
  - During WAIT: mem_address is held at the latched address, mem_read = 1, mem_write = 0.
  - In the last WAIT cycle (wait_cnt == 1), mem_data_out is captured into the owner's rdata register; state -> RESP.
  - RESP: owner's rvalid = 1 for one cycle; state -> IDLE.
  - Read occupancy is MEM_LAT+2 cycles from the issue cycle to the first possible next issue.
- cpu_stall = cpu_req & ~(CPU write issued this cycle | cpu_rvalid).
  - It therefore stays high while the LDR owns the memory.
- Outside issue and WAIT: mem_read = mem_write = 0; mem_address and mem_write_data hold their last value.
- Loader read hold: the LDR may deassert ldr_req after ldr_gnt; its read response is still delivered.
- Reset mid-operation: the in-flight read is abandoned, no rvalid pulse, all state returns to reset values.
- rdata registers hold their value until the next read for that owner.

Decomposition:
- Package dmem_arb_pkg:
  - state enum {IDLE, WAIT, RESP}
  - owner encoding {OWN_CPU = 0, OWN_LDR = 1}
  - width constants ADDR_W and DATA_W
- One sub-module, dmem_arb_fairness:
  - Contains burst_cnt and the grant decision.
  - Inputs cpu_req, ldr_req, idle.
  - Outputs grant_cpu, grant_ldr.
- Everything else is in dmem_arbiter.

Test Plan:
- After reset: cpu_req = 0, ldr_req = 0 -> all outputs 0, state IDLE. Then cpu_req=1 write addr 0x10, data 0xDEADBEEF -> in the same cycle mem_write = 1, mem_address = 0x10, cpu_stall = 0.
- CPU read of 0x10 with MEM_LAT = 1 -> mem_read high for 2 cycles; cpu_stall high for 2 cycles; in the 3rd cycle cpu_rvalid = 1, cpu_rdata = 0xDEADBEEF, cpu_stall = 0.
- cpu_req and ldr_req both held, all writes, MAX_CPU_BURST = 4 -> grant sequence CPU, CPU, CPU, CPU, LDR, CPU...; ldr_gnt pulses exactly once per 5 cycles.
- LDR read of 0x20 issued while cpu_req rises in the next cycle -> CPU stalled through WAIT and RESP; ldr_rvalid pulses; the CPU is granted in the following IDLE cycle.
- reset asserted in the WAIT cycle of a CPU read -> no cpu_rvalid; the next cycle is IDLE with mem_read = 0; a request after reset completes normally.
- MEM_LAT = 3 build: read -> exactly 3 WAIT cycles, rvalid in the 5th cycle after issue, captured data equal to the memory contents.
